// File: rtl/intpol2_iq_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : intpol2_iq_out_packer
// Brief    : Drains the I/Q interpolator output FIFOs in lockstep and packs
//            each pair into a {Q,I} valid/ready stream word with frame-end.
// Revision : 1.0 - initial release
// ============================================================================
module intpol2_iq_out_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    frame_len,
    input  logic                    Empty_I_i,
    input  logic                    Empty_Q_i,
    input  logic [DATA_WIDTH-1:0]   data_I_i,
    input  logic [DATA_WIDTH-1:0]   data_Q_i,
    output logic                    Read_Enable_fifo,
    output logic [2*DATA_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [LEN_WIDTH-1:0]    count_o,
    output logic [7:0]              status_reg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LEN_WIDTH-1:0] c_len_one = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]              r_state;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_req;
    logic [LEN_WIDTH-1:0]    r_count;
    logic                    r_inflight;
    logic [2*DATA_WIDTH-1:0] r_mem [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_occ;
    logic                    r_skew_err;
    logic                    r_len_err;

    logic                    w_hs;
    logic [2:0]              w_pending;
    logic                    w_re;
    logic [1:0]              w_occ_nxt;
    logic                    w_cnt_inc;
    logic [LEN_WIDTH-1:0]    w_count_nxt;

    assign m_valid = (r_occ != 2'd0);
    assign w_hs    = m_valid & m_ready;

    // A pop in this cycle frees its slot, so streaming sustains one read per cycle.
    assign w_pending = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_hs};
    assign w_re      = (r_state == S_RUN) & ~Empty_I_i & ~Empty_Q_i &
                       (r_req < r_len) & (w_pending < 3'd2);

    assign w_occ_nxt   = r_occ + {1'b0, r_inflight} - {1'b0, w_hs};
    assign w_cnt_inc   = w_hs & (r_count != r_len);
    assign w_count_nxt = w_cnt_inc ? (r_count + c_len_one) : r_count;

    assign Read_Enable_fifo = w_re;
    assign m_data           = r_mem[r_rd_ptr];
    assign m_last           = m_valid & (r_count == (r_len - c_len_one));
    assign count_o          = r_count;
    assign status_reg       = {4'b0000, r_len_err, r_skew_err,
                               (r_state == S_RUN) | (r_state == S_DRAIN),
                               (r_state == S_DONE)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_req      <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_occ      <= 2'd0;
            r_skew_err <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_inflight <= w_re;
            if (r_inflight) begin
                r_mem[r_wr_ptr] <= {data_Q_i, data_I_i};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_hs) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ   <= w_occ_nxt;
            r_count <= w_count_nxt;
            if (w_re) begin
                r_req <= r_req + c_len_one;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (frame_len != '0) begin
                            r_len      <= frame_len;
                            r_count    <= '0;
                            r_req      <= '0;
                            r_skew_err <= 1'b0;
                            r_len_err  <= 1'b0;
                            r_state    <= S_RUN;
                        end else begin
                            r_len_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (Empty_I_i != Empty_Q_i) begin
                        r_skew_err <= 1'b1;
                    end
                    if (w_re && ((r_req + c_len_one) == r_len)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Look ahead so DONE follows the final handshake directly.
                    if ((w_occ_nxt == 2'd0) && (w_count_nxt == r_len)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intpol2_iq_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_intpol2_iq_out_packer
// Brief    : Directed bench with FIFO model and expected-word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intpol2_iq_out_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] frame_len;
    logic        Empty_I_i;
    logic        Empty_Q_i;
    logic [15:0] data_I_i;
    logic [15:0] data_Q_i;
    logic        Read_Enable_fifo;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [15:0] count_o;
    logic [7:0]  status_reg;

    intpol2_iq_out_packer #(.DATA_WIDTH(16), .LEN_WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .frame_len        (frame_len),
        .Empty_I_i        (Empty_I_i),
        .Empty_Q_i        (Empty_Q_i),
        .data_I_i         (data_I_i),
        .data_Q_i         (data_Q_i),
        .Read_Enable_fifo (Read_Enable_fifo),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_last           (m_last),
        .count_o          (count_o),
        .status_reg       (status_reg)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shared-pointer model of the two output FIFOs (both popped by one RE).
    logic [15:0] mem_i [0:255];
    logic [15:0] mem_q [0:255];
    int          wp = 0;
    int          rp = 0;
    logic        force_ei = 1'b0;
    logic        force_eq = 1'b0;

    assign Empty_I_i = (wp == rp) | force_ei;
    assign Empty_Q_i = (wp == rp) | force_eq;

    always @(posedge clk) begin
        if (Read_Enable_fifo) begin
            data_I_i <= mem_i[rp];
            data_Q_i <= mem_q[rp];
            rp       <= rp + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q [$];
    int          re_cyc [$];
    int          n_out = 0;
    int          widx = 0;
    int          cur_len = 0;
    int          first_hs_cyc = 0;
    int          last_hs_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        chk_lat = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [31:0] mon_e;
    int          mon_r;
    logic        mon_hs;

    // Stream monitor: sampled mid-cycle, models the handshake on the next edge.
    always @(negedge clk) begin
        mon_hs = m_valid && m_ready && !rst;
        if (prev_stall) begin
            check("stall_valid", {31'b0, m_valid}, 32'd1);
            check("stall_data", m_data, prev_data);
            check("stall_last", {31'b0, m_last}, {31'b0, prev_last});
        end
        if (Read_Enable_fifo) begin
            check("re_room", ((n_out - (mon_hs ? 1 : 0)) < 2) ? 32'd1 : 32'd0, 32'd1);
            n_out++;
            re_cyc.push_back(cyc);
        end
        if (mon_hs) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 32'd0, 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("word", m_data, mon_e);
                check("last", {31'b0, m_last}, (widx == cur_len - 1) ? 32'd1 : 32'd0);
            end
            if (re_cyc.size() != 0) begin
                mon_r = re_cyc.pop_front();
                if (chk_lat) check("latency", cyc - mon_r, 32'd2);
            end
            if (widx == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            widx++;
            n_out--;
        end
        if (status_reg[0]) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst) begin
            for (int k = 0; k < n_out; k++) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            re_cyc.delete();
            n_out = 0;
        end
        prev_stall = m_valid && !m_ready && !rst;
        prev_data  = m_data;
        prev_last  = m_last;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [15:0] i_val, input logic [15:0] q_val);
        mem_i[wp] = i_val;
        mem_q[wp] = q_val;
        wp = wp + 1;
        exp_q.push_back({q_val, i_val});
    endtask

    task automatic do_start(input int len);
        start     = 1'b1;
        frame_len = 16'(len);
        cur_len   = len;
        widx      = 0;
        done_cnt  = 0;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done_cnt > 0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("done_seen", {31'b0, found}, 32'd1);
        if (found) begin
            check("done_after_last_hs", done_cyc, last_hs_cyc + 1);
            check("done_count", done_cnt, 32'd1);
            @(negedge clk);
            check("idle_after_done", {30'b0, status_reg[1:0]}, 32'd0);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pat [4];
        int         remaining;
        logic       hit;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        rst = 1'b1; start = 1'b0; frame_len = '0; m_ready = 1'b0;
        data_I_i = '0; data_Q_i = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_re", {31'b0, Read_Enable_fifo}, 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_valid_last", {30'b0, m_valid, m_last}, 32'd0);
        check("rst_count", {16'b0, count_o}, 32'd0);
        check("rst_status", {24'b0, status_reg}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Streaming frame: I=k, Q=-k
        for (int k = 0; k < 16; k++) push_pair(16'(k), 16'(-k));
        m_ready = 1'b1;
        chk_lat = 1'b1;
        do_start(16);
        @(negedge clk);
        check("first_re", {31'b0, Read_Enable_fifo}, 32'd1);
        check("busy_run", {31'b0, status_reg[1]}, 32'd1);
        wait_done(60);
        check("stream_words", widx, 32'd16);
        check("stream_throughput", last_hs_cyc - first_hs_cyc, 32'd15);
        check("stream_count", {16'b0, count_o}, 32'd16);

        // Backpressure 1,0,0,1
        chk_lat = 1'b0;
        for (int k = 0; k < 8; k++) push_pair(16'($urandom), 16'($urandom));
        do_start(8);
        for (int c = 0; c < 60; c++) begin
            m_ready = pat[c % 4][0];
            step();
        end
        m_ready = 1'b1;
        wait_done(10);
        check("bp_words", widx, 32'd8);
        check("bp_sb_empty", exp_q.size(), 32'd0);
        check("bp_count", {16'b0, count_o}, 32'd8);

        // Sparse input: one pair every 3 cycles
        chk_lat = 1'b1;
        do_start(4);
        for (int k = 0; k < 4; k++) begin
            push_pair(16'(16'h8000 + k), 16'(16'h7FF0 - k));
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (k < 3) check("sparse_busy", {31'b0, status_reg[1]}, 32'd1);
                step();
            end
        end
        wait_done(20);
        check("sparse_words", widx, 32'd4);

        // Length error
        chk_lat = 1'b0;
        push_pair(16'h1234, 16'hABCD);
        push_pair(16'h0F0F, 16'hF0F0);
        do_start(0);
        hit = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (Read_Enable_fifo) hit = 1'b1;
            if (c == 0) begin
                check("len_err_set", {31'b0, status_reg[3]}, 32'd1);
                check("len_err_busy", {31'b0, status_reg[1]}, 32'd0);
            end
            step();
        end
        check("len_err_no_re", {31'b0, hit}, 32'd0);
        do_start(2);
        @(negedge clk);
        check("len_err_cleared", {31'b0, status_reg[3]}, 32'd0);
        step();
        wait_done(20);
        check("len2_count", {16'b0, count_o}, 32'd2);

        // Skew: Q FIFO reports empty while I has data
        force_eq = 1'b1;
        push_pair(16'h0001, 16'hFFFF);
        push_pair(16'h7FFF, 16'h8000);
        do_start(2);
        hit = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (Read_Enable_fifo) hit = 1'b1;
            if (c == 1) check("skew_set", {31'b0, status_reg[2]}, 32'd1);
            step();
        end
        check("skew_no_re", {31'b0, hit}, 32'd0);
        force_eq = 1'b0;
        wait_done(20);
        check("skew_sticky", {31'b0, status_reg[2]}, 32'd1);
        check("skew_words", widx, 32'd2);

        // Reset mid-frame
        for (int k = 0; k < 8; k++) push_pair(16'(16'h0100 + k), 16'(16'h0200 + k));
        do_start(8);
        @(negedge clk);
        check("skew_cleared", {31'b0, status_reg[2]}, 32'd0);
        step();
        for (int c = 0; c < 40; c++) begin
            if (widx >= 3) break;
            step();
        end
        check("pre_rst_words", widx, 32'd3);
        m_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_re", {31'b0, Read_Enable_fifo}, 32'd0);
        check("mid_rst_outs", {m_data[29:0], m_valid, m_last}, 32'd0);
        check("mid_rst_count", {16'b0, count_o}, 32'd0);
        check("mid_rst_status", {24'b0, status_reg}, 32'd0);
        step();
        check("fifo_vs_sb", wp - rp, exp_q.size());
        m_ready = 1'b1;
        remaining = exp_q.size();
        for (int k = remaining; k < 5; k++) push_pair(16'(16'h0300 + k), 16'(16'h0400 + k));
        do_start(5);
        wait_done(30);
        check("post_rst_words", widx, 32'd5);
        check("post_rst_count", {16'b0, count_o}, 32'd5);
        check("final_sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
